// File: rtl/pc_seq_ctrl_if.sv
// Purpose: bundles the PC sequencer's EX-result inputs, next-PC adder link and fetch handshake.
// Latency: wiring only, no state.
// Backpressure: imem_ready carries fetch backpressure into the sequencer.
interface pc_seq_ctrl_if;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_br;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_br_taken;
  logic [31:0] npc;
  logic        imem_ready;
  logic [31:0] pc;
  logic        if_valid;
  logic [1:0]  pc_sel;
  logic        jump;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] stat_redirects;
  logic [31:0] stat_br_taken;

  // Sequencer side: owns pc and the adder selects.
  modport master (
    input  stall, ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_br_taken, npc, imem_ready,
    output pc, if_valid, pc_sel, jump, flush_if_id, flush_id_ex, stat_redirects, stat_br_taken
  );

  // Pipeline/adder/fetch side.
  modport slave (
    output stall, ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_br_taken, npc, imem_ready,
    input  pc, if_valid, pc_sel, jump, flush_if_id, flush_id_ex, stat_redirects, stat_br_taken
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Purpose: PC sequencer, predict-not-taken, flushes on EX redirect, buffers redirects while fetch blocked.
// Latency: pc updates one cycle after an accepted fetch; redirect target lands the cycle after imem_ready.
// Backpressure: pc held stable while if_valid & !imem_ready. Optional counters under BRANCH_STAT_EN.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] pend_pc_q;
  logic [31:0] pend_pc_nxt;
  logic        pend_exit_q;
  logic        redirect;
  logic        br_taken;
  logic        jump_c;

  // The pipeline is empty in BOOT, so EX results are ignored there.
  assign br_taken = bus.ex_valid & bus.ex_is_br & bus.ex_br_taken;
  assign redirect = (state != BOOT) &
                    (bus.ex_valid & (bus.ex_is_jal | bus.ex_is_jalr) | br_taken);

  // State register plus PC, buffered redirect target and PEND-exit marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      pend_pc_q   <= 32'h0;
      pend_exit_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      pend_pc_q   <= pend_pc_nxt;
      pend_exit_q <= (state == PEND) & bus.imem_ready;
    end
  end

  // Next state and next PC; a redirect always beats the load-use stall.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    pend_pc_nxt = pend_pc_q;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          if (bus.imem_ready) begin
            pc_nxt = bus.npc;
          end else begin
            pend_pc_nxt = bus.npc;
            state_nxt   = PEND;
          end
        end else if (!bus.stall && bus.imem_ready) begin
          pc_nxt = bus.npc;
        end
      end
      PEND: begin
        // Younger EX result replaces the buffered target.
        if (redirect) begin
          pend_pc_nxt = bus.npc;
        end
        if (bus.imem_ready) begin
          pc_nxt    = redirect ? bus.npc : pend_pc_q;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Adder selects, fetch valid and flushes; IF/ID is also killed on the first cycle after PEND.
  always_comb begin
    bus.pc_sel      = 2'b00;
    jump_c          = 1'b0;
    bus.if_valid    = (state != BOOT);
    bus.flush_id_ex = redirect & (state == RUN);
    bus.flush_if_id = (redirect & (state == RUN)) | pend_exit_q;
    if (state != BOOT) begin
      if (bus.ex_valid & bus.ex_is_jal) begin
        bus.pc_sel = 2'b01;
      end else if (bus.ex_valid & bus.ex_is_jalr) begin
        bus.pc_sel = 2'b10;
      end else if (br_taken) begin
        bus.pc_sel = 2'b11;
      end
      jump_c = br_taken;
    end
  end

  assign bus.pc   = pc_q;
  assign bus.jump = jump_c;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_redirects_q;
  logic [31:0] stat_br_taken_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_redirects_q <= 32'h0;
      stat_br_taken_q  <= 32'h0;
    end else begin
      if (redirect) stat_redirects_q <= stat_redirects_q + 32'd1;
      if (jump_c)   stat_br_taken_q  <= stat_br_taken_q + 32'd1;
    end
  end

  assign bus.stat_redirects = stat_redirects_q;
  assign bus.stat_br_taken  = stat_br_taken_q;
`else
  assign bus.stat_redirects = 32'h0;
  assign bus.stat_br_taken  = 32'h0;
`endif

endmodule
